// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM-like data bus: size encodings, bus widths
// and the response-queue entry layout.
package sram_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_e;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic [3:0]        cnt;
   } resp_entry_t;

endpackage

// File: rtl/resp_fifo.sv
// In-order response queue. Each entry carries a countdown that ages it to
// zero; only an aged head may be popped.
module resp_fifo
   import sram_bus_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int LATENCY = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic              o_full,
   output logic              o_head_valid,
   output logic              o_head_ready,
   output logic [DATA_W-1:0] o_head_rdata
);

   localparam int         PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   resp_entry_t      r_ent [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_full       = &r_vld;
   assign o_head_valid = r_vld[r_rd_ptr];
   assign o_head_ready = (r_ent[r_rd_ptr].cnt == 4'd0);
   assign o_head_rdata = r_ent[r_rd_ptr].rdata;

   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && o_head_valid;

   // Push and pop never touch the same slot: equal pointers mean empty or full.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld    <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (w_do_push) begin
            r_vld[r_wr_ptr] <= 1'b1;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= next_ptr(r_rd_ptr);
         end
      end
   end

   // Ageing runs on every slot; stale slots are masked by r_vld.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (w_do_push && (r_wr_ptr == PTR_W'(i))) begin
            r_ent[i].rdata <= i_push_data;
            r_ent[i].cnt   <= CNT_INIT;
         end else if (r_ent[i].cnt != 4'd0) begin
            r_ent[i].cnt <= r_ent[i].cnt - 4'd1;
         end
      end
   end

endmodule

// File: rtl/data_sram_responder.sv
// Responder side of the data SRAM-like bus: word-addressed memory with byte
// strobes, answering every accepted request in order after a fixed latency.
module data_sram_responder
   import sram_bus_pkg::*;
#(
   parameter int MEM_WORDS       = 1024,
   parameter int LATENCY         = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              data_sram_req,
   input  logic              data_sram_wr,
   input  logic [1:0]        data_sram_size,
   input  logic [3:0]        data_sram_wstrb,
   input  logic [ADDR_W-1:0] data_sram_addr,
   input  logic [DATA_W-1:0] data_sram_wdata,
   output logic              data_sram_addr_ok,
   output logic              data_sram_data_ok,
   output logic [DATA_W-1:0] data_sram_rdata,
   input  logic              resp_hold
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   logic [DATA_W-1:0] r_mem [MEM_WORDS];
   logic [IDX_W-1:0]  w_idx;
   logic              w_accept;
   logic              w_full;
   logic              w_head_valid;
   logic              w_head_ready;
   logic [DATA_W-1:0] w_head_rdata;
   logic [DATA_W-1:0] w_push_data;
   logic              w_unused_bits;

   // Size only matters to the requester; upper and lane address bits wrap away.
   assign w_unused_bits = &{1'b0, data_sram_size, data_sram_addr[ADDR_W-1:IDX_W+2],
                            data_sram_addr[1:0]};

   assign w_idx             = data_sram_addr[IDX_W+1:2];
   assign data_sram_addr_ok = resetn && !w_full;
   assign w_accept          = data_sram_req && data_sram_addr_ok;
   assign w_push_data       = data_sram_wr ? '0 : r_mem[w_idx];

   assign data_sram_data_ok = w_head_valid && w_head_ready && !resp_hold;
   assign data_sram_rdata   = data_sram_data_ok ? w_head_rdata : '0;

   // Memory is deliberately outside reset so contents survive resetn pulses.
   always_ff @(posedge clk) begin
      if (w_accept && data_sram_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (data_sram_wstrb[b]) begin
               r_mem[w_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
         end
      end
   end

   resp_fifo #(
      .DEPTH   (MAX_OUTSTANDING),
      .LATENCY (LATENCY)
   ) u_resp_fifo (
      .i_clk        (clk),
      .i_rst_n      (resetn),
      .i_push       (w_accept),
      .i_push_data  (w_push_data),
      .i_pop        (data_sram_data_ok),
      .o_full       (w_full),
      .o_head_valid (w_head_valid),
      .o_head_ready (w_head_ready),
      .o_head_rdata (w_head_rdata)
   );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: single-transaction vector table plus
// sequences for back-to-back, full queue, hold and mid-flight reset.
module tb_data_sram_responder;
   import sram_bus_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        hold;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  strb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   data_sram_responder dut (
      .clk               (clk),
      .resetn            (resetn),
      .data_sram_req     (req),
      .data_sram_wr      (wr),
      .data_sram_size    (size),
      .data_sram_wstrb   (wstrb),
      .data_sram_addr    (addr),
      .data_sram_wdata   (wdata),
      .data_sram_addr_ok (addr_ok),
      .data_sram_data_ok (data_ok),
      .data_sram_rdata   (rdata),
      .resp_hold         (hold)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input logic [1:0] sz,
                        input logic [3:0] sb, input logic [31:0] a, input logic [31:0] d);
      req = r; wr = w; size = sz; wstrb = sb; addr = a; wdata = d;
   endtask

   function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic [3:0] sb,
                               input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
      vec_t v;
      v.wr = w; v.size = sz; v.strb = sb; v.addr = a; v.wdata = d; v.exp = e;
      return v;
   endfunction

   // One isolated transaction on an idle queue: accept in T0, response in T2.
   task automatic run_vec(input string nm, input vec_t v);
      drive(1'b1, v.wr, v.size, v.strb, v.addr, v.wdata);
      @(negedge clk);
      chk({nm, " addr_ok T0"}, {31'd0, addr_ok}, 32'd1);
      chk({nm, " data_ok T0"}, {31'd0, data_ok}, 32'd0);
      step();
      req = 1'b0;
      @(negedge clk);
      chk({nm, " data_ok T1"}, {31'd0, data_ok}, 32'd0);
      step();
      @(negedge clk);
      chk({nm, " data_ok T2"}, {31'd0, data_ok}, 32'd1);
      chk({nm, " rdata T2"}, rdata, v.exp);
      step();
   endtask

   initial begin
      logic [7:0]  e_aok;
      logic [7:0]  e_dok;
      int          nacc;
      int          nresp;

      resetn = 1'b0;
      hold   = 1'b0;
      drive(1'b0, 1'b0, SIZE_W, 4'h0, 32'h0, 32'h0);

      vecs[0]  = mk(1'b1, SIZE_W, 4'hF, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0);
      vecs[1]  = mk(1'b1, SIZE_H, 4'h2, 32'h0000_0020, 32'h0000_AB00, 32'h0);
      vecs[2]  = mk(1'b0, SIZE_W, 4'h0, 32'h0000_0020, 32'h0,         32'hFFFF_ABFF);
      vecs[3]  = mk(1'b0, SIZE_H, 4'h0, 32'h0000_0022, 32'h0,         32'hFFFF_ABFF);
      vecs[4]  = mk(1'b1, SIZE_W, 4'hF, 32'h0000_1004, 32'hA5A5_A5A5, 32'h0);
      vecs[5]  = mk(1'b0, SIZE_W, 4'h0, 32'h0000_0004, 32'h0,         32'hA5A5_A5A5);
      vecs[6]  = mk(1'b1, SIZE_W, 4'hF, 32'h0000_0030, 32'h0102_0304, 32'h0);
      vecs[7]  = mk(1'b1, SIZE_W, 4'h9, 32'h0000_0030, 32'hDEAD_BEEF, 32'h0);
      vecs[8]  = mk(1'b1, SIZE_W, 4'h0, 32'h0000_0030, 32'hFFFF_FFFF, 32'h0);
      vecs[9]  = mk(1'b0, 2'd3,   4'h0, 32'h0000_0030, 32'h0,         32'hDE02_03EF);
      vecs[10] = mk(1'b1, SIZE_W, 4'hF, 32'h0000_0FFC, 32'h1234_5678, 32'h0);
      vecs[11] = mk(1'b0, SIZE_B, 4'h0, 32'hFFFF_FFFC, 32'h0,         32'h1234_5678);
      vecs[12] = mk(1'b1, SIZE_W, 4'hF, 32'h0000_0050, 32'hA000_0000, 32'h0);
      vecs[13] = mk(1'b1, SIZE_W, 4'hF, 32'h0000_0054, 32'hA000_0001, 32'h0);
      vecs[14] = mk(1'b1, SIZE_W, 4'hF, 32'h0000_0058, 32'hA000_0002, 32'h0);
      vecs[15] = mk(1'b1, SIZE_W, 4'hF, 32'h0000_005C, 32'hA000_0003, 32'h0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      req = 1'b1;
      chk("reset addr_ok", {31'd0, addr_ok}, 32'd0);
      chk("reset data_ok", {31'd0, data_ok}, 32'd0);
      chk("reset rdata", rdata, 32'd0);
      resetn = 1'b1;
      #1;
      chk("first cycle addr_ok", {31'd0, addr_ok}, 32'd1);

      // Back-to-back write then read
      drive(1'b1, 1'b1, SIZE_W, 4'hF, 32'h0000_0040, 32'h1122_3344);
      @(negedge clk);
      chk("b2b addr_ok T0", {31'd0, addr_ok}, 32'd1);
      step();
      drive(1'b1, 1'b0, SIZE_W, 4'h0, 32'h0000_0040, 32'h0);
      @(negedge clk);
      chk("b2b addr_ok T1", {31'd0, addr_ok}, 32'd1);
      chk("b2b data_ok T1", {31'd0, data_ok}, 32'd0);
      step();
      req = 1'b0;
      @(negedge clk);
      chk("b2b data_ok T2", {31'd0, data_ok}, 32'd1);
      chk("b2b rdata T2", rdata, 32'h0);
      step();
      @(negedge clk);
      chk("b2b data_ok T3", {31'd0, data_ok}, 32'd1);
      chk("b2b rdata T3", rdata, 32'h1122_3344);
      step();
      @(negedge clk);
      chk("b2b data_ok T4", {31'd0, data_ok}, 32'd0);
      step();

      for (int i = 0; i < NV; i++) begin
         run_vec($sformatf("vec%0d", i), vecs[i]);
      end

      // Full queue: four reads with req held high
      e_aok = 8'b1101_1011;
      e_dok = 8'b0110_1100;
      nacc  = 0;
      nresp = 0;
      for (int t = 0; t < 8; t++) begin
         drive(nacc < 4, 1'b0, SIZE_W, 4'h0, 32'h50 + 32'(4 * nacc), 32'h0);
         @(negedge clk);
         chk($sformatf("full addr_ok T%0d", t), {31'd0, addr_ok}, {31'd0, e_aok[t]});
         chk($sformatf("full data_ok T%0d", t), {31'd0, data_ok}, {31'd0, e_dok[t]});
         if (e_dok[t]) begin
            chk($sformatf("full rdata T%0d", t), rdata, 32'hA000_0000 + 32'(nresp));
            nresp++;
         end
         if (req && e_aok[t]) nacc++;
         step();
      end
      req = 1'b0;

      // Hold: aged head waits until resp_hold drops
      drive(1'b1, 1'b0, SIZE_W, 4'h0, 32'h0000_0054, 32'h0);
      hold = 1'b1;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         chk($sformatf("hold data_ok T%0d", t), {31'd0, data_ok}, 32'd0);
         chk($sformatf("hold rdata T%0d", t), rdata, 32'd0);
         step();
         req = 1'b0;
      end
      hold = 1'b0;
      @(negedge clk);
      chk("hold data_ok T6", {31'd0, data_ok}, 32'd1);
      chk("hold rdata T6", rdata, 32'hA000_0001);
      step();
      for (int t = 7; t < 9; t++) begin
         @(negedge clk);
         chk($sformatf("hold data_ok T%0d", t), {31'd0, data_ok}, 32'd0);
         step();
      end

      // Reset mid-flight with two reads outstanding
      drive(1'b1, 1'b0, SIZE_W, 4'h0, 32'h0000_0040, 32'h0);
      step();
      drive(1'b1, 1'b0, SIZE_W, 4'h0, 32'h0000_0050, 32'h0);
      step();
      req = 1'b0;
      #1;
      resetn = 1'b0;
      #1;
      chk("rst data_ok", {31'd0, data_ok}, 32'd0);
      chk("rst addr_ok", {31'd0, addr_ok}, 32'd0);
      @(negedge clk);
      chk("rst data_ok neg", {31'd0, data_ok}, 32'd0);
      step();
      resetn = 1'b1;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         chk($sformatf("post-rst data_ok %0d", t), {31'd0, data_ok}, 32'd0);
         chk($sformatf("post-rst addr_ok %0d", t), {31'd0, addr_ok}, 32'd1);
         step();
      end
      run_vec("post-rst mem", mk(1'b0, SIZE_W, 4'h0, 32'h0000_0040, 32'h0, 32'h1122_3344));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Responder end of the data-side SRAM-like bus driven by the EX stage (request) and consumed by the MEM stage (`data_sram_data_ok` / `data_sram_rdata`). It accepts requests with `addr_ok`, performs byte-strobed writes and word reads against an internal word-addressed memory, and returns in-order responses after a fixed latency, with up to `MAX_OUTSTANDING` requests in flight. It is the bench/SoC-side model the pipeline talks to and sits outside the CPU core.

## Interface
- `MEM_WORDS`, 1024: memory depth in 32-bit words; power of two.
- `LATENCY`, 2: cycles from request acceptance to earliest `data_ok`; legal range 1–15.
- `MAX_OUTSTANDING`, 2: response queue depth; power of two, at least 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `data_sram_req`  in  1  request valid.
- `data_sram_wr`  in  1  1 = write, 0 = read.
- `data_sram_size`  in  2  0 = byte, 1 = half, 2 = word; informational only.
- `data_sram_wstrb`  in  4  byte enables for writes.
- `data_sram_addr`  in  32  byte address.
- `data_sram_wdata`  in  32  write data, already lane-aligned.
- `data_sram_addr_ok`  out  1  request accepted this cycle.
- `data_sram_data_ok`  out  1  response valid this cycle.
- `data_sram_rdata`  out  32  read word; 0 for write responses.
- `resp_hold`  in  1  bench back-pressure; suppresses `data_ok` while high.

## Operation
- Accept condition: `addr_ok = resetn && !q_full`, independent of `req`; a transfer happens when `req && addr_ok`. There is no same-cycle bypass: a queue that is full stays non-accepting even when it pops in the same cycle.
- Index: `addr[log2(MEM_WORDS)+1:2]`. Upper bits are ignored, so addresses wrap. `addr[1:0]` is ignored.
- Write on accept: memory is updated at that edge for each byte `i` where `wstrb[i]` is set. `wstrb` = 0 is a legal no-op. A queue entry is pushed with `rdata` = 0.
- Read on accept: the full indexed word is sampled at accept time, so it reflects every earlier accepted write. The word is pushed into the queue entry. Byte and half extraction are the MEM stage's job; this block always returns the whole word.
- Queue entry contents: `{rdata[31:0], cnt[3:0]}`.
  - `cnt` is loaded with `LATENCY-1` on push.
  - Every valid entry with `cnt != 0` decrements it each cycle, regardless of `resp_hold`.
- Response rule: `data_ok = head_valid && head.cnt == 0 && !resp_hold`. `rdata` = `head.rdata` when `data_ok` is high, otherwise 0. The head pops on `data_ok`.
- Responses are strictly in acceptance order. Exactly one `data_ok` is returned per accepted request.
- Pipeline flushes (ertn, exception, TLB refetch) are invisible to this block. Every accepted request is answered.
- Simultaneous push and pop: both take effect and the occupancy count is unchanged.
- `size` = 3 is treated as a word with no error.
- Reset, asynchronous:
  - Queue empties and all pending responses are dropped.
  - `addr_ok` = 0 and `data_ok` = 0 while `resetn` is low.
  - Memory contents are not reset.
  - The first accept is possible in the first cycle with `resetn` high.

## Timing
- A request accepted in cycle T gives earliest `data_ok` in cycle T+`LATENCY`.
- Back-to-back accepts in T and T+1 give responses in T+L and T+L+1 when `MAX_OUTSTANDING` ≥ 2.
- Throughput is 1 request per cycle when `MAX_OUTSTANDING` > `LATENCY`. Otherwise `addr_ok` drops once the queue is full and rises in the cycle after the pop.
- With `resp_hold` high, an aged head waits. `data_ok` fires in the first cycle `resp_hold` is low, and younger entries respond in consecutive following cycles if already aged.
- `addr_ok` is combinational from queue state only (no input to output path from `req`). `data_ok` and `rdata` are combinational from queue state and `resp_hold`.

## Structure
- Shared package `sram_bus_pkg`: size encodings (`SIZE_B`, `SIZE_H`, `SIZE_W`), `ADDR_W` = 32, `DATA_W` = 32, and a resp-entry typedef `{rdata, cnt}`.
- Sub-module `resp_fifo`: a parameterised in-order queue with per-entry countdown, exposing `push`, `pop`, `full`, `head_valid` and `head_ready`.
- The memory array and byte-write logic live in the top module.

## Test plan
- Defaults. Write `addr` 0x10, wdata 0x11223344, wstrb 0xF in T0, then read 0x10 in T1.
  - `addr_ok` is high both cycles.
  - `data_ok` in T2 with rdata 0, and in T3 with rdata 0x11223344.
- Partial strobe. Prefill 0x20 = 0xFFFFFFFF. Write wdata 0x0000AB00 with wstrb 0x2, then read 0x20.
  - Read returns 0xFFFFABFF.
  - Also read 0x22: same word, `size` = 1.
- Full queue. Defaults, `req` held high for 4 reads.
  - Accepts in T0 and T1.
  - `addr_ok` = 0 in T2 (queue full), with a pop that cycle.
  - Accept resumes in T3.
  - `data_ok` in T2, T3, T5 and T6 with matching data order.
- Hold. Read accepted T0, `resp_hold` high T0–T5.
  - No `data_ok` through T5.
  - `data_ok` in T6 with the correct word.
  - Exactly one response.
- Wrap. `MEM_WORDS` = 1024. Write 0x0000_1004 with data 0xA5A5A5A5, read 0x0000_0004.
  - Returns 0xA5A5A5A5.
- Reset mid-flight. Two reads accepted, `resetn` pulsed low asynchronously mid-cycle before any response.
  - `data_ok` and `addr_ok` go 0 immediately.
  - No responses after release.
  - Earlier written memory data survives.
